// File: rtl/ptcalc_mul_arb_pkg.sv
// Shared constants, id-width helper and pipeline-stage record for the shared multiplier arbiter.
package ptcalc_mul_arb_pkg;

    localparam int NUM_REQ_DEF     = 4;
    localparam int MUL_LATENCY_DEF = 3;
    localparam int A_WIDTH_DEF     = 19;
    localparam int B_WIDTH_DEF     = 12;
    localparam int ID_W_MAX        = 3;

    function automatic int id_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

    // Sideband travelling alongside each operand/product; an empty stage carries id=0.
    typedef struct packed {
        logic                valid;
        logic [ID_W_MAX-1:0] id;
    } stage_ctrl_t;

endpackage

// File: rtl/ptcalc_mul_arb_pipe.sv
// Enable-gated signed multiplier: operand stage, MUL_LATENCY product stages (last one is the output register).
module ptcalc_mul_arb_pipe
    import ptcalc_mul_arb_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int A_WIDTH     = A_WIDTH_DEF,
    parameter int B_WIDTH     = B_WIDTH_DEF,
    parameter int P_WIDTH     = A_WIDTH_DEF + B_WIDTH_DEF,
    parameter int ID_W        = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [ID_W-1:0]           in_id,
    input  logic signed [A_WIDTH-1:0] in_a,
    input  logic signed [B_WIDTH-1:0] in_b,
    input  logic                      res_ready,
    output logic                      en,
    output logic                      res_valid,
    output logic [ID_W-1:0]           res_id,
    output logic [P_WIDTH-1:0]        res_p,
    output logic                      busy
);

    stage_ctrl_t               op_ctrl_q, op_ctrl_d;
    logic signed [A_WIDTH-1:0] op_a_q, op_a_d;
    logic signed [B_WIDTH-1:0] op_b_q, op_b_d;
    stage_ctrl_t               mul_ctrl_q [MUL_LATENCY];
    stage_ctrl_t               mul_ctrl_d [MUL_LATENCY];
    logic signed [P_WIDTH-1:0] mul_p_q [MUL_LATENCY];
    logic signed [P_WIDTH-1:0] mul_p_d [MUL_LATENCY];

    assign en        = ~mul_ctrl_q[MUL_LATENCY-1].valid | res_ready;
    assign res_valid = mul_ctrl_q[MUL_LATENCY-1].valid;
    assign res_id    = mul_ctrl_q[MUL_LATENCY-1].id[ID_W-1:0];
    assign res_p     = mul_p_q[MUL_LATENCY-1];

    always_comb begin
        op_ctrl_d  = op_ctrl_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        mul_ctrl_d = mul_ctrl_q;
        mul_p_d    = mul_p_q;
        if (en) begin
            op_ctrl_d.valid = in_valid;
            op_ctrl_d.id    = in_valid ? ID_W_MAX'(in_id) : '0;
            op_a_d          = in_a;
            op_b_d          = in_b;
            mul_ctrl_d[0]   = op_ctrl_q;
            mul_p_d[0]      = P_WIDTH'(op_a_q) * P_WIDTH'(op_b_q);
            for (int s = 1; s < MUL_LATENCY; s++) begin
                mul_ctrl_d[s] = mul_ctrl_q[s-1];
                mul_p_d[s]    = mul_p_q[s-1];
            end
        end
    end

    // Empty stages hold an all-zero record, so any nonzero record means occupied.
    always_comb begin
        busy = (op_ctrl_q != '0);
        for (int s = 0; s < MUL_LATENCY; s++) begin
            busy = busy | (mul_ctrl_q[s] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_ctrl_q <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            for (int s = 0; s < MUL_LATENCY; s++) begin
                mul_ctrl_q[s] <= '0;
                mul_p_q[s]    <= '0;
            end
        end else begin
            op_ctrl_q <= op_ctrl_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            for (int s = 0; s < MUL_LATENCY; s++) begin
                mul_ctrl_q[s] <= mul_ctrl_d[s];
                mul_p_q[s]    <= mul_p_d[s];
            end
        end
    end

endmodule

// File: rtl/ptcalc_mul_arbiter.sv
// Arbiter sharing one pipelined signed multiplier among NUM_REQ requesters.
// PTCALC_MUL_ARB_RR_EN defined: round-robin pointer; undefined: fixed priority, lowest index wins.
module ptcalc_mul_arbiter
    import ptcalc_mul_arb_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int A_WIDTH     = A_WIDTH_DEF,
    parameter int B_WIDTH     = B_WIDTH_DEF,
    parameter int P_WIDTH     = A_WIDTH + B_WIDTH
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [id_width(NUM_REQ)-1:0] res_id,
    output logic [P_WIDTH-1:0]           res_p,
    output logic                         busy
);

    localparam int ID_W = id_width(NUM_REQ);

    logic                      en;
    logic                      gnt_any;
    logic                      gnt_go;
    logic [ID_W-1:0]           gnt_idx;
    logic signed [A_WIDTH-1:0] sel_a;
    logic signed [B_WIDTH-1:0] sel_b;

`ifdef PTCALC_MUL_ARB_RR_EN
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    gnt_off;
    logic [ID_W:0]      idx_sum;
    logic [NUM_REQ-1:0] req_rot;

    // Rotate so bit 0 is the requester at ptr; the lowest set bit is the winner.
    always_comb begin
        gnt_any = 1'b0;
        gnt_off = '0;
        req_rot = NUM_REQ'({req_valid, req_valid} >> ptr_q);
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (req_rot[off]) begin
                gnt_any = 1'b1;
                gnt_off = ID_W'(off);
            end
        end
        idx_sum = {1'b0, ptr_q} + {1'b0, gnt_off};
        gnt_idx = (idx_sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(idx_sum - (ID_W+1)'(NUM_REQ))
                                                  : idx_sum[ID_W-1:0];
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_go) begin
            ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(i);
            end
        end
    end
`endif

    // Grants are withheld in reset and while the output register is stalled.
    assign gnt_go = gnt_any & en & ap_rst_n;

    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                req_ready[i] = gnt_go;
                sel_a        = req_a[i*A_WIDTH +: A_WIDTH];
                sel_b        = req_b[i*B_WIDTH +: B_WIDTH];
            end
        end
    end

    ptcalc_mul_arb_pipe #(
        .MUL_LATENCY (MUL_LATENCY),
        .A_WIDTH     (A_WIDTH),
        .B_WIDTH     (B_WIDTH),
        .P_WIDTH     (P_WIDTH),
        .ID_W        (ID_W)
    ) u_pipe (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .in_valid  (gnt_go),
        .in_id     (gnt_idx),
        .in_a      (sel_a),
        .in_b      (sel_b),
        .res_ready (res_ready),
        .en        (en),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_p     (res_p),
        .busy      (busy)
    );

endmodule

// File: tb/tb_ptcalc_mul_arbiter.sv
// Bench for ptcalc_mul_arbiter: directed vectors, per-cycle compare against an age-queue model, literal pins.
module tb_ptcalc_mul_arbiter;

    localparam int N  = 4;
    localparam int L  = 3;
    localparam int AW = 19;
    localparam int BW = 12;
    localparam int PW = AW + BW;
    localparam int IW = 2;
    localparam int EW = IW + PW;
`ifdef PTCALC_MUL_ARB_RR_EN
    localparam bit RR_BUILD = 1'b1;
`else
    localparam bit RR_BUILD = 1'b0;
`endif

    logic          ap_clk    = 1'b0;
    logic          ap_rst_n  = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [N*AW-1:0] req_a;
    logic [N*BW-1:0] req_b;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [IW-1:0] res_id;
    logic [PW-1:0] res_p;
    logic          busy;

    int op_a [N];
    int op_b [N];

    // Model: accepted results in order, each with the number of enabled edges it has aged.
    logic [EW-1:0] exp_q[$];
    int            age_q[$];
    int            ptr_m = 0;

    int checks   = 0;
    int failures = 0;

    always #5 ap_clk = ~ap_clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*AW +: AW] = AW'(op_a[i]);
            req_b[i*BW +: BW] = BW'(op_b[i]);
        end
    end

    ptcalc_mul_arbiter dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_p     (res_p),
        .busy      (busy)
    );

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int model_pick(input logic [N-1:0] v, input int p);
        if (RR_BUILD) begin
            for (int off = 0; off < N; off++) if (v[(p + off) % N]) return (p + off) % N;
        end else begin
            for (int i = 0; i < N; i++) if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic int oh2idx(input logic [N-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Compare process: outputs are stable at the falling edge; model then advances for the next rising edge.
    always @(negedge ap_clk) begin
        logic         exp_rv;
        logic         en_m;
        int           pick;
        logic [N-1:0] exp_rr;
        logic [EW-1:0] head;
        longint       prod;
        if (!ap_rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_busy", busy, 0);
            exp_q.delete();
            age_q.delete();
            ptr_m = 0;
        end else begin
            exp_rv = (age_q.size() > 0) && (age_q[0] >= L);
            en_m   = !exp_rv || res_ready;
            pick   = model_pick(req_valid, ptr_m);
            exp_rr = (en_m && pick >= 0) ? (N'(1) << pick) : '0;
            chk("req_ready", req_ready, exp_rr);
            chk("res_valid", res_valid, exp_rv);
            chk("busy", busy, exp_q.size() != 0);
            if (exp_rv) begin
                head = exp_q[0];
                chk("res_id", res_id, head[EW-1:PW]);
                chk("res_p", $signed(res_p), $signed(head[PW-1:0]));
            end
            if (en_m) begin
                if (exp_rv && res_ready) begin
                    void'(exp_q.pop_front());
                    void'(age_q.pop_front());
                end
                foreach (age_q[k]) age_q[k] = age_q[k] + 1;
                if (pick >= 0) begin
                    prod = longint'(op_a[pick]) * longint'(op_b[pick]);
                    exp_q.push_back({IW'(pick), PW'(prod)});
                    age_q.push_back(0);
                    if (RR_BUILD) ptr_m = (pick + 1) % N;
                end
            end
        end
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        op_a[i] = a;
        op_b[i] = b;
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        step();
        step();
        ap_rst_n = 1'b1;
    endtask

    task automatic drain();
        res_ready = 1'b1;
        for (int i = 0; i < 40 && busy; i++) step();
        chk("drain_busy", busy, 0);
        chk("drain_model_empty", exp_q.size(), 0);
    endtask

    task automatic wait_result(output int id, output longint p);
        id = -1;
        p  = 0;
        for (int i = 0; i < 20; i++) begin
            if (res_valid) begin
                id = int'(res_id);
                p  = $signed(res_p);
                step();
                return;
            end
            step();
        end
        chk("wait_result_timeout", res_valid, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int     rid;
        longint rp;
        // Power-on reset with every requester asserting.
        #1;
        ap_rst_n  = 1'b0;
        req_valid = '1;
        res_ready = 1'b1;
        #2;
        chk("por_res_valid", res_valid, 0);
        chk("por_busy", busy, 0);
        chk("por_res_p", res_p, 0);
        chk("por_res_id", res_id, 0);
        chk("por_req_ready", req_ready, 0);
        step();
        step();
        req_valid = '0;
        ap_rst_n  = 1'b1;

        // Single request: 100 * -3 from requester 0, three cycles latency.
        step();
        req_valid = 4'b0001;
        set_op(0, 100, -3);
        #1;
        chk("t1_req_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        chk("t1_lat0", res_valid, 0);
        step();
        chk("t1_lat1", res_valid, 0);
        step();
        chk("t1_lat2", res_valid, 0);
        step();
        chk("t1_lat3_valid", res_valid, 1);
        chk("t1_res_id", res_id, 0);
        chk("t1_res_p", $signed(res_p), -300);
        chk("t1_busy_hold", busy, 1);
        step();
        chk("t1_after_valid", res_valid, 0);
        chk("t1_after_busy", busy, 0);

        // All requesters continuously valid.
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 5000 - 3000 * i, 17 * i - 40);
        req_valid = '1;
        #1;
        for (int c = 0; c < 12; c++) begin
            chk("t2_grant", oh2idx(req_ready), RR_BUILD ? (c % N) : 0);
            chk("t2_res_valid", res_valid, c >= 4);
            step();
            #1;
        end
        req_valid = '0;
        drain();

        // Extreme operands.
        step();
        req_valid = 4'b0100;
        set_op(2, -262144, -2048);
        step();
        req_valid = 4'b1000;
        set_op(3, 262143, 2047);
        step();
        req_valid = '0;
        wait_result(rid, rp);
        chk("t3_id_min", rid, 2);
        chk("t3_p_min", rp, 64'sd536870912);
        wait_result(rid, rp);
        chk("t3_id_max", rid, 3);
        chk("t3_p_max", rp, 64'sd536606721);
        drain();

        // Fill the pipeline, then stall the output for five cycles.
        for (int i = 0; i < N; i++) set_op(i, 300 * i - 700, 11 - 9 * i);
        req_valid = '1;
        res_ready = 1'b1;
        repeat (6) step();
        res_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t4_stall_req_ready", req_ready, 0);
            chk("t4_stall_res_valid", res_valid, 1);
            step();
        end
        res_ready = 1'b1;
        req_valid = '0;
        drain();

        // Reset with three operations in flight.
        set_op(1, 123, -45);
        set_op(2, -777, 99);
        set_op(3, 4096, -1);
        req_valid = 4'b1110;
        res_ready = 1'b1;
        repeat (3) step();
        chk("t5_busy_before", busy, 1);
        req_valid = '1;
        ap_rst_n  = 1'b0;
        #1;
        chk("t5_rst_res_valid", res_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_req_ready", req_ready, 0);
        step();
        step();
        ap_rst_n = 1'b1;
        #1;
        chk("t5_first_grant", req_ready, 4'b0001);
        req_valid = '0;
        for (int c = 0; c < 8; c++) begin
            step();
            chk("t5_no_ghost", res_valid, 0);
        end
        chk("t5_busy_after", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ptcalc_mul_arbiter.md
PTCALC_MUL_ARBITER -- requirements
Module: ptcalc_mul_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the multiplier (2..8).
REQ-002 Parameter MUL_LATENCY, default 3, multiplier pipeline depth in cycles (1..6).
REQ-003 Parameter A_WIDTH, default 19, signed operand A width.
REQ-004 Parameter B_WIDTH, default 12, signed operand B width.
REQ-005 Parameter P_WIDTH, default A_WIDTH+B_WIDTH, signed product width.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-007 ap_clk  in  1  sole clock; all state on rising edge.
REQ-008 ap_rst_n  in  1  asynchronous active-low reset.
REQ-009 req_valid  in  NUM_REQ  per-requester operand valid.
REQ-010 req_ready  out  NUM_REQ  per-requester grant/accept.
REQ-011 req_a  in  NUM_REQ*A_WIDTH  packed signed operand A; requester i at slice i.
REQ-012 req_b  in  NUM_REQ*B_WIDTH  packed signed operand B; requester i at slice i.
REQ-013 res_valid  out  1  result valid.
REQ-014 res_ready  in  1  downstream accepts result.
REQ-015 res_id  out  clog2(NUM_REQ)  index of the requester that owns the result.
REQ-016 res_p  out  P_WIDTH  full-precision signed product.
REQ-017 busy  out  1  high while any pipeline stage or the output register holds a valid entry.

Function
REQ-018 Pipeline enable en = !res_valid | res_ready; all stages and the output register advance only when en=1.
REQ-019 At most one req_ready bit SHALL be high per cycle; it SHALL be high only when en=1 and the corresponding req_valid=1; req_ready is combinational from req_valid, the priority pointer and en.
REQ-020 Transfer on req_valid[i] & req_ready[i]; operands and id i are captured into stage 1 that edge.
REQ-021 Each stage holds {valid, id, a, b} or a partial product; the product is the exact signed a*b, no truncation or saturation.
REQ-022 With no stall, res_valid SHALL rise exactly MUL_LATENCY cycles after the accepting edge; sustained throughput is one product per cycle.
REQ-023 res_valid, res_id and res_p SHALL hold stable while res_valid=1 and res_ready=0.
REQ-024 Results SHALL leave in acceptance order; no result is dropped or duplicated under any res_ready pattern.
REQ-025 Priority pointer ptr: after a grant to i, ptr = (i+1) mod NUM_REQ (wraps NUM_REQ-1 to 0); ptr SHALL NOT change on cycles without a grant.
REQ-026 Arbitration picks the first requesting index at or after ptr, searching upward with wrap.
REQ-027 A requester holding req_valid high with stable operands SHALL be granted within NUM_REQ cycles of en being high (round-robin build).

Reset
REQ-028 On ap_rst_n=0, all stage valid bits, res_valid, res_id, res_p, busy and ptr SHALL be 0 immediately (asynchronous); req_ready=0 during reset.
REQ-029 In-flight operations are discarded on reset; no result for them SHALL appear after reset release.
REQ-030 First grant is possible on the first rising edge after ap_rst_n deasserts.

Configuration
REQ-031 Macro PTCALC_MUL_ARB_RR_EN: defined -> round-robin per REQ-025..027; undefined -> fixed priority, lowest index wins, ptr register absent and REQ-027 waived.

Structure
REQ-032 Package ptcalc_mul_arb_pkg SHALL hold default width constants, the clog2 id-width function and the pipeline-stage record typedef.
REQ-033 Sub-module ptcalc_mul_arb_pipe SHALL implement the enable-gated MUL_LATENCY-stage signed multiplier with id/valid sideband; the arbiter and ptr live in the top.

Verification
REQ-034 Requester 0 only, a=100, b=-3, res_ready=1 -> res_valid after 3 cycles, res_id=0, res_p=-300, busy low the following cycle.
REQ-035 All 4 requesters valid continuously, RR build -> grant order 0,1,2,3,0,1..., one result per cycle; fixed build -> 0,0,0,...
REQ-036 a=-262144, b=-2048 -> res_p=536870912; a=262143, b=2047 -> res_p=536606721.
REQ-037 Pipeline full, res_ready=0 for 5 cycles -> req_ready all 0, res_* stable; after release, all results delivered in order, none lost.
REQ-038 ap_rst_n pulsed low with 3 operations in flight -> res_valid=0 and busy=0 immediately, no result emitted after release, next grant goes to requester 0.
